// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the receiver and the transmitter.
//   state_t            : receiver/transmitter frame state (IDLE, START, DATA, PAR, STOP)
//   PAR_NONE/ODD/EVEN  : encoding of the PARITY parameter
//   calc_clks_per_bit  : default bit period in system clocks
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Integer division truncates; the resulting bit-rate error must stay
    // well inside the half-bit sampling margin for the chosen clock.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk  : destination clock
//   rst  : asynchronous active-low reset; both flops load RESET_VAL
//   d    : asynchronous input
//   q    : synchronized output, 2 clocks after d
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so meta and q
    // both update from their pre-edge values, giving a true 2-stage chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers DATA_BITS-wide frames from an asynchronous line,
// checks optional parity and the stop bit, and holds each good byte in a
// valid/ready register for the downstream consumer.
//   clk, rst    : system clock, asynchronous active-low reset
//   rx_in       : serial line, idle high, asynchronous to clk
//   rx_data     : received byte, LSB first on the line
//   rx_valid    : rx_data holds an unconsumed byte
//   rx_ready    : consumer takes rx_data when rx_valid && rx_ready
//   rx_busy     : a frame is being received
//   frame_err   : 1-clock pulse, stop bit sampled low
//   parity_err  : 1-clock pulse, parity mismatch
//   overrun     : 1-clock pulse, good frame dropped because rx_valid was held
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE),
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);

    state_t                 state;
    logic [CNT_W-1:0]       baud_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_bad;
    logic                   wait_high;
    logic                   rx_s;
    logic                   exp_par;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    // Even parity: the parity bit makes the total count of ones even.
    assign exp_par = (PARITY == PAR_EVEN) ? ^shift_reg : ~^shift_reg;
    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            wait_high  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;

            // NOTE: a later non-blocking assignment in the same block wins, so
            // a byte loaded in STOP below overrides this consume and keeps
            // rx_valid high.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    par_bad  <= 1'b0;
                    // After a break the line must go high before a new start.
                    if (rx_s) begin
                        wait_high <= 1'b0;
                    end else if (!wait_high) begin
                        state <= START;
                    end
                end

                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        if (rx_s) begin
                            state <= IDLE;      // glitch, not a start bit
                        end else begin
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= DATA;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        baud_cnt  <= '0;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PAR: begin
                    if (baud_cnt == BIT_LAST) begin
                        par_bad  <= (rx_s != exp_par);
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    // Leaving at mid stop bit re-arms for a back-to-back start.
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            wait_high <= 1'b1;
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Two receivers share the clock: index 0 has
// no parity, index 1 has even parity. Frames go to one receiver at a time; the
// bench predicts the event each frame must produce (delivery, frame error,
// parity error, overrun) into a queue, and a compare process matches every
// observed event against that queue.
module tb_uart_rx;

    localparam int CPB    = 16;
    localparam int EV_DEL = 0;
    localparam int EV_FE  = 1;
    localparam int EV_PE  = 2;
    localparam int EV_OVR = 3;

    typedef struct {
        int         dut;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in      [2];
    logic       rx_ready   [2];
    logic [7:0] rx_data    [2];
    logic       rx_valid   [2];
    logic       rx_busy    [2];
    logic       frame_err  [2];
    logic       parity_err [2];
    logic       overrun    [2];

    int n_checks = 0;
    int n_pass   = 0;

    ev_t        exp_q[$];
    bit         mvalid [2];
    logic [7:0] mdata  [2];

    bit         prev_valid [2];
    bit         prev_hs    [2];
    bit         prev_fe    [2];
    bit         prev_pe    [2];
    bit         prev_ov    [2];
    logic [7:0] prev_data  [2];

    int         n_del = 0, n_fe = 0, n_pe = 0, n_ovr = 0, n_valid0 = 0;
    logic [7:0] last_del = 8'h00;
    int         b_del, b_fe, b_pe, b_ovr, b_v0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ(100_000_000), .BAUD_RATE(9600), .CLKS_PER_BIT(CPB),
        .DATA_BITS(8), .PARITY(0)
    ) dut0 (
        .clk(clk), .rst(rst), .rx_in(rx_in[0]), .rx_data(rx_data[0]),
        .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .rx_busy(rx_busy[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun(overrun[0])
    );

    uart_rx #(
        .CLK_FREQ(100_000_000), .BAUD_RATE(9600), .CLKS_PER_BIT(CPB),
        .DATA_BITS(8), .PARITY(2)
    ) dut1 (
        .clk(clk), .rst(rst), .rx_in(rx_in[1]), .rx_data(rx_data[1]),
        .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .rx_busy(rx_busy[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun(overrun[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void expect_ev(input int k, input int kind, input logic [7:0] d);
        ev_t e;
        e.dut  = k;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input int k, input int kind, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: dut %0d kind %0d data %0h, expected none (t=%0t)",
                     k, kind, d, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_dut", k, e.dut);
            check("event_kind", kind, e.kind);
            if (kind == EV_DEL) check("event_data", d, e.data);
        end
    endtask

    // Consumer side of the model: raising ready releases a held byte.
    task automatic set_ready(input int k, input bit v);
        rx_ready[k] = v;
        if (v && mvalid[k]) begin
            expect_ev(k, EV_DEL, mdata[k]);
            mvalid[k] = 1'b0;
        end
    endtask

    // Drives one frame and records the outcome the receiver must report.
    task automatic send_frame(input int k, input logic [7:0] d, input bit par_good,
                              input bit stop, input int gap);
        logic pbit;
        if (!stop)                       expect_ev(k, EV_FE, d);
        else if (k == 1 && !par_good)    expect_ev(k, EV_PE, d);
        else if (rx_ready[k])            expect_ev(k, EV_DEL, d);
        else if (mvalid[k])              expect_ev(k, EV_OVR, d);
        else begin
            mvalid[k] = 1'b1;
            mdata[k]  = d;
        end
        rx_in[k] = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in[k] = d[i];
            tick(CPB);
        end
        if (k == 1) begin
            pbit = ($countones(d) % 2 == 1);
            if (!par_good) pbit = ~pbit;
            rx_in[k] = pbit;
            tick(CPB);
        end
        rx_in[k] = stop;
        tick(CPB);
        rx_in[k] = 1'b1;
        if (gap > 0) tick(gap);
    endtask

    task automatic snap();
        b_del = n_del; b_fe = n_fe; b_pe = n_pe; b_ovr = n_ovr; b_v0 = n_valid0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                prev_valid[k] = 1'b0;
                prev_hs[k]    = 1'b0;
                prev_fe[k]    = 1'b0;
                prev_pe[k]    = 1'b0;
                prev_ov[k]    = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rx_valid[k] && prev_valid[k] && !prev_hs[k])
                    check("data_stable", rx_data[k], prev_data[k]);
                if (rx_valid[k] && rx_ready[k]) begin
                    observe(k, EV_DEL, rx_data[k]);
                    last_del = rx_data[k];
                    n_del++;
                end
                if (frame_err[k]) begin
                    check("frame_err_width", prev_fe[k], 0);
                    observe(k, EV_FE, 8'h00);
                    n_fe++;
                end
                if (parity_err[k]) begin
                    check("parity_err_width", prev_pe[k], 0);
                    observe(k, EV_PE, 8'h00);
                    n_pe++;
                end
                if (overrun[k]) begin
                    check("overrun_width", prev_ov[k], 0);
                    observe(k, EV_OVR, 8'h00);
                    n_ovr++;
                end
                if (k == 0 && rx_valid[0]) n_valid0++;
                prev_valid[k] = rx_valid[k];
                prev_hs[k]    = rx_valid[k] && rx_ready[k];
                prev_fe[k]    = frame_err[k];
                prev_pe[k]    = parity_err[k];
                prev_ov[k]    = overrun[k];
                prev_data[k]  = rx_data[k];
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rx_in[k]    = 1'b1;
            rx_ready[k] = 1'b1;
            mvalid[k]   = 1'b0;
        end
        tick(3);
        for (int k = 0; k < 2; k++) begin
            check("reset_rx_data", rx_data[k], 0);
            check("reset_rx_valid", rx_valid[k], 0);
            check("reset_rx_busy", rx_busy[k], 0);
            check("reset_errors", {frame_err[k], parity_err[k], overrun[k]}, 0);
        end
        rst = 1'b1;
        tick(4);

        // 0xA5, no parity, ready high: one-cycle rx_valid, no errors.
        snap();
        fork
            send_frame(0, 8'hA5, 1'b1, 1'b1, 2 * CPB);
            begin
                tick(4 * CPB);
                check("busy_mid_frame", rx_busy[0], 1);
            end
        join
        check("pending_a5", exp_q.size(), 0);
        check("a5_data", last_del, 8'hA5);
        check("a5_valid_cycles", n_valid0 - b_v0, 1);
        check("a5_no_errors", (n_fe - b_fe) + (n_pe - b_pe) + (n_ovr - b_ovr), 0);
        check("busy_after_frame", rx_busy[0], 0);

        // Even parity: 0xCC has four ones, so parity bit 0 is correct.
        snap();
        send_frame(1, 8'hCC, 1'b1, 1'b1, 2 * CPB);
        check("cc_good_data", last_del, 8'hCC);
        check("cc_good_del", n_del - b_del, 1);
        snap();
        send_frame(1, 8'hCC, 1'b0, 1'b1, 2 * CPB);
        check("cc_bad_pe", n_pe - b_pe, 1);
        check("cc_bad_no_del", n_del - b_del, 0);
        check("cc_bad_valid", rx_valid[1], 0);

        // Stop bit forced low: frame_err, holding register untouched.
        snap();
        send_frame(0, 8'h3C, 1'b1, 1'b0, 2 * CPB);
        check("3c_fe", n_fe - b_fe, 1);
        check("3c_data_kept", rx_data[0], 8'hA5);
        check("3c_valid", rx_valid[0], 0);
        check("pending_3c", exp_q.size(), 0);

        // Back-to-back with consumer stalled: second byte overruns.
        set_ready(0, 1'b0);
        snap();
        send_frame(0, 8'h11, 1'b1, 1'b1, 0);
        send_frame(0, 8'h22, 1'b1, 1'b1, CPB);
        check("b2b_ovr", n_ovr - b_ovr, 1);
        check("b2b_data_held", rx_data[0], 8'h11);
        check("b2b_valid_held", rx_valid[0], 1);
        set_ready(0, 1'b1);
        tick(3);
        check("b2b_consumed", last_del, 8'h11);
        check("b2b_valid_clear", rx_valid[0], 0);
        check("pending_b2b", exp_q.size(), 0);

        // Short low glitch is rejected, next frame is clean.
        snap();
        rx_in[0] = 1'b0;
        tick(3);
        rx_in[0] = 1'b1;
        tick(2 * CPB);
        check("glitch_no_events", (n_del - b_del) + (n_fe - b_fe) + (n_ovr - b_ovr), 0);
        check("glitch_idle", rx_busy[0], 0);
        send_frame(0, 8'hAB, 1'b1, 1'b1, CPB);
        check("ab_data", last_del, 8'hAB);

        // Reset in the middle of 0xBC: the partial frame vanishes.
        rx_in[0] = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_in[0] = (i == 2 || i == 3);
            tick(CPB);
        end
        rst = 1'b0;
        rx_in[0] = 1'b1;
        for (int k = 0; k < 2; k++) mvalid[k] = 1'b0;
        tick(3);
        check("midreset_busy", rx_busy[0], 0);
        rst = 1'b1;
        tick(3);
        snap();
        send_frame(0, 8'h5A, 1'b1, 1'b1, CPB);
        check("5a_data", last_del, 8'h5A);
        check("5a_one_del", n_del - b_del, 1);
        check("5a_no_errors", (n_fe - b_fe) + (n_pe - b_pe) + (n_ovr - b_ovr), 0);

        // Randomized frames across both receivers.
        for (int n = 0; n < 40; n++) begin
            int         k;
            logic [7:0] d;
            bit         pg;
            bit         st;
            int         gap;
            k   = $urandom_range(0, 1);
            d   = 8'($urandom);
            pg  = ($urandom_range(0, 5) != 0);
            st  = ($urandom_range(0, 7) != 0);
            gap = st ? $urandom_range(0, 40) : CPB + $urandom_range(0, 20);
            set_ready(k, 1'($urandom_range(0, 1)));
            send_frame(k, d, pg, st, gap);
            check("pending_random", exp_q.size(), 0);
        end

        set_ready(0, 1'b1);
        set_ready(1, 1'b1);
        tick(4);
        check("queue_drained", exp_q.size(), 0);
        check("final_valid0", rx_valid[0], 0);
        check("final_valid1", rx_valid[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: recovers 8-bit (parameterizable) frames from an asynchronous line, checks optional parity and the stop bit, and presents each byte on a valid/ready holding register. Sits at the device pin, opposite the transmitter in the Uart-8bits design, and feeds the downstream byte consumer (FIFO or command decoder).

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz
- BAUD_RATE, 9600: line bit rate
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE: clocks per bit; must be ≥ 4. Overriding it directly is allowed for simulation.
- DATA_BITS, 8: data bits per frame, 5–9
- PARITY, 0: 0 none, 1 odd, 2 even
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rx_in  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  DATA_BITS  received byte, LSB = first bit on line
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
- rx_busy  out  1  frame reception in progress (state ≠ IDLE)
- frame_err  out  1  one-cycle pulse: sampled stop bit was 0
- parity_err  out  1  one-cycle pulse: parity mismatch (PARITY≠0 only)
- overrun  out  1  one-cycle pulse: frame completed while rx_valid still set

## Operation
- rx_in passes through a 2-flop synchronizer with reset value 1. rx_s is the synchronized value.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: when rx_s == 0 (edge or level low), clear baud_cnt and go to START.
- START: at baud_cnt == CLKS_PER_BIT/2 − 1 (mid start bit):
  - rx_s == 1: glitch; return to IDLE with no flags.
  - rx_s == 0: clear baud_cnt, clear bit_cnt, go to DATA.
- DATA: at each baud_cnt == CLKS_PER_BIT − 1, shift rx_s into shift_reg MSB-side (right shift, so LSB is first) and clear baud_cnt. After bit DATA_BITS−1, go to PAR if PARITY≠0, otherwise STOP.
- PAR: sample at the same interval. Expected parity is ^data (even) or ~^data (odd). Record a mismatch and go to STOP.
- STOP: sample at mid stop bit, then go to IDLE immediately. This re-arms for a back-to-back start bit half a bit early.
- Completion in the STOP sample cycle:
  - Stop bit = 0: pulse frame_err. Data is discarded, rx_valid is unchanged, and no parity_err pulse is produced.
  - Stop bit = 1, parity mismatch: pulse parity_err and discard the data.
  - Otherwise, good frame:
    - if rx_valid == 0 or rx_ready == 1 in that cycle: load rx_data and set rx_valid.
    - else: pulse overrun and keep the old rx_data (new byte is dropped).
- Handshake: rx_valid clears on a cycle with rx_ready && rx_valid, unless a new good byte loads in the same cycle (load wins, rx_valid stays 1).
- rx_data is stable while rx_valid is 1.
- A line held low (break) produces frame_err once. The receiver then re-enters START only after rx_s returns high and falls again; IDLE requires rx_s high for ≥1 cycle after a frame_err.
- Reset mid-frame: all state is cleared asynchronously and the partial frame is lost. The first falling edge after reset release starts a new frame.

## Timing
- Output reset values: rx_data = 0, rx_valid = 0, rx_busy = 0, frame_err = parity_err = overrun = 0. FSM resets to IDLE, counters to 0.
- Synchronizer latency: 2 clocks from rx_in change to rx_s.
- Data bit n is sampled at (falling edge + 2) + CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT clocks, ±1.
- rx_valid and the error pulses are registered. They are visible the cycle after the mid-stop-bit sample.
- Error pulses are exactly 1 clock wide.
- Counter widths: baud_cnt is $clog2(CLKS_PER_BIT) bits; bit_cnt is 4 bits.

## Structure
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PAR, STOP)
  - PARITY encoding constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2)
  - CLKS_PER_BIT derivation function
  - the transmitter uses the same package.
- One sub-module: uart_sync2 (2-flop synchronizer with reset value parameter). FSM, counters and holding register stay in uart_rx.

## Test plan
- CLKS_PER_BIT=16, PARITY=0, send 0xA5 (line bits 1,0,1,0,0,1,0,1), rx_ready=1 → rx_data=0xA5, rx_valid for 1 cycle, no error pulses.
- PARITY=2, send 0xCC with parity bit 0 → accepted. Same byte with parity bit 1 → parity_err pulse, rx_valid stays 0.
- Send 0x3C with stop bit forced 0 → frame_err pulse, rx_data unchanged.
- rx_ready=0, send 0x11 then 0x22 back-to-back → rx_data=0x11 held, overrun pulse at end of second frame. Then rx_ready=1 → 0x11 consumed, rx_valid=0.
- Low glitch on rx_in of 3 clocks (< CLKS_PER_BIT/2) → returns to IDLE, no rx_valid or error. A following 0xAB frame is received correctly.
- Assert rst mid DATA of 0xBC frame, release, send 0x5A → only 0x5A is delivered, no error pulses.
